// File: rtl/gen_round_keys_if.sv
// gen_round_keys_if: key-schedule bus between the key-receive logic / round datapath and gen_round_keys
//   chg_key         master->slave  request to load rx_key and rebuild the schedule
//   rx_key          master->slave  128-bit cipher key, bit 127 = MSB of word w0
//   cur_round       master->slave  requested round index (0-10 valid)
//   cur_key         slave->master  registered round key for cur_round
//   orig_key        slave->master  registered copy of the last loaded cipher key
//   change_key_done slave->master  one-cycle pulse when the schedule is complete
interface gen_round_keys_if;
   logic         chg_key;
   logic [127:0] rx_key;
   logic [3:0]   cur_round;
   logic [127:0] cur_key;
   logic [127:0] orig_key;
   logic         change_key_done;
   modport master(output chg_key, rx_key, cur_round, input cur_key, orig_key, change_key_done);
   modport slave(input chg_key, rx_key, cur_round, output cur_key, orig_key, change_key_done);
endinterface

// File: rtl/gen_round_keys.sv
// gen_round_keys: AES-128 key expansion; stores all 11 round keys and serves one per cycle
//   clk    rising-edge clock
//   n_rst  asynchronous active-low reset
//   bus    gen_round_keys_if.slave (chg_key, rx_key, cur_round in; cur_key, orig_key, change_key_done out)
// Optional build macro GRK_FAST_EXPAND_EN: expand two rounds per cycle (8 S-box lookups).
module gen_round_keys (
   input  logic             clk,
   input  logic             n_rst,
   gen_round_keys_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE, HOLD} state_t;
   localparam logic [7:0] sbox [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
   // padded to 16 entries so any 4-bit counter value indexes a defined constant
   localparam logic [7:0] rcon [16] = '{
      8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00};
`ifdef GRK_FAST_EXPAND_EN
   localparam logic [3:0] last_cnt = 4'd9;
`else
   localparam logic [3:0] last_cnt = 4'd10;
`endif
   state_t       state, state_nx;
   logic [3:0]   cnt;
   logic [127:0] sched [11];
   logic [127:0] nk1;
`ifdef GRK_FAST_EXPAND_EN
   logic [127:0] nk2;
`endif
   function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      // SubWord(RotWord(p3)): p3 = p[31:0], rotated left by one byte
      t  = {sbox[p[23:16]], sbox[p[15:8]], sbox[p[7:0]], sbox[p[31:24]]} ^ {rc, 24'h0};
      n0 = p[127:96] ^ t;
      n1 = p[95:64] ^ n0;
      n2 = p[63:32] ^ n1;
      n3 = p[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction
   always_comb begin
      nk1 = key_step(sched[cnt - 4'd1], rcon[cnt]);
`ifdef GRK_FAST_EXPAND_EN
      nk2 = key_step(nk1, rcon[cnt + 4'd1]);
`endif
      state_nx = state == IDLE   ? (bus.chg_key ? EXPAND : IDLE) :
                 state == EXPAND ? (cnt == last_cnt ? DONE : EXPAND) :
                 bus.chg_key ? HOLD : IDLE;
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         cnt                 <= '0;
         bus.cur_key         <= '0;
         bus.orig_key        <= '0;
         bus.change_key_done <= 1'b0;
         for (int i = 0; i < 11; i++) sched[i] <= '0;
      end else begin
         bus.change_key_done <= state == DONE;
         if (state != EXPAND) bus.cur_key <= bus.cur_round <= 4'd10 ? sched[bus.cur_round] : '0;
         if (state == IDLE && bus.chg_key) begin
            bus.orig_key <= bus.rx_key;
            sched[0]     <= bus.rx_key;
            cnt          <= 4'd1;
         end
         if (state == EXPAND) begin
`ifdef GRK_FAST_EXPAND_EN
            sched[cnt]         <= nk1;
            sched[cnt + 4'd1]  <= nk2;
            cnt                <= cnt + 4'd2;
`else
            sched[cnt] <= nk1;
            cnt        <= cnt + 4'd1;
`endif
         end
      end
endmodule

// File: tb/tb_gen_round_keys.sv
// tb_gen_round_keys: directed self-checking bench for gen_round_keys (AES-128 key schedule)
module tb_gen_round_keys;
   logic tb_clk = 1'b0;
   logic n_rst;
   int   n_checks = 0;
   int   n_fail = 0;
   int   lat, pulses;
`ifdef GRK_FAST_EXPAND_EN
   localparam int exp_lat = 6;
`else
   localparam int exp_lat = 11;
`endif
   localparam logic [127:0] hello = 128'h68656c6c6f3030303030303030303030;
   localparam logic [127:0] fips  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [127:0] hello_rk [11];
   gen_round_keys_if bus();
   gen_round_keys dut (.clk(tb_clk), .n_rst(n_rst), .bus(bus));
   always #5 tb_clk = ~tb_clk;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run_load(input logic [127:0] key, input int hold, output int l, output int p);
      bus.rx_key  = key;
      bus.chg_key = 1'b1;
      @(posedge tb_clk);
      #1;
      l = -1;
      p = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c > hold) bus.chg_key = 1'b0;
         @(posedge tb_clk);
         #1;
         if (bus.change_key_done) begin
            p++;
            if (l < 0) l = c;
         end
      end
      bus.chg_key = 1'b0;
   endtask
   task automatic read_round(input logic [3:0] r, input string tag, input logic [127:0] exp);
      bus.cur_round = r;
      @(posedge tb_clk);
      #1;
      check(tag, bus.cur_key, exp);
   endtask
   initial begin
      hello_rk = '{hello,
         128'h6d616868025158583261686802515858, 128'hbe0b021fbc5a5a478e3b322f8c6a6a77,
         128'hb809f77b0453ad3c8a689f130602f564, 128'hc7efb414c3bc192849d4863b4fd6735f,
         128'h21607b90e2dc62b8ab08e483e4de97dc, 128'h1ce8fdf9fe349f41553c7bc2b1e2ec1e,
         128'hc4268f313a1210706f2e6bb2decc87ac, 128'h0f311e2c35230e5c5a0d65ee84c1e242,
         128'h6ca93273598a3c2f038759c18746bb83, 128'h0043de6459c9e24b5a4ebb8add080009};
      n_rst = 1'b0;
      bus.chg_key = 1'b0;
      bus.rx_key = '0;
      bus.cur_round = '0;
      repeat (3) @(posedge tb_clk);
      #1;
      check("rst_cur_key", bus.cur_key, '0);
      check("rst_orig_key", bus.orig_key, '0);
      check("rst_done", {127'h0, bus.change_key_done}, '0);
      n_rst = 1'b1;
      @(posedge tb_clk);
      #1;
      run_load(hello, 11, lat, pulses);
      check("hello_latency", 128'(lat), 128'(exp_lat));
      check("hello_pulses", 128'(pulses), 128'd1);
      check("hello_orig_key", bus.orig_key, hello);
      for (int r = 1; r <= 10; r++) read_round(4'(r), $sformatf("hello_rk%0d", r), hello_rk[r]);
      read_round(4'd0, "hello_rk0", hello);
      read_round(4'd10, "hello_rk10_again", hello_rk[10]);
      read_round(4'd1, "hello_rk1_after_10", hello_rk[1]);
      read_round(4'd12, "round12_zero", '0);
      read_round(4'd15, "round15_zero", '0);
      run_load(hello, 30, lat, pulses);
      check("hold30_pulses", 128'(pulses), 128'd1);
      check("hold30_latency", 128'(lat), 128'(exp_lat));
      run_load(fips, 11, lat, pulses);
      check("fips_latency", 128'(lat), 128'(exp_lat));
      check("fips_orig_key", bus.orig_key, fips);
      read_round(4'd1, "fips_rk1", 128'ha0fafe1788542cb123a339392a6c7605);
      read_round(4'd0, "fips_rk0", fips);
      read_round(4'd10, "fips_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      bus.rx_key = hello;
      bus.chg_key = 1'b1;
      @(posedge tb_clk);
      #1;
      bus.chg_key = 1'b0;
      repeat (3) @(posedge tb_clk);
      #1;
      check("expand_holds_cur_key", bus.cur_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("expand_orig_key", bus.orig_key, hello);
      n_rst = 1'b0;
      #1;
      check("midrst_cur_key", bus.cur_key, '0);
      check("midrst_orig_key", bus.orig_key, '0);
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if (c == 2) n_rst = 1'b1;
         @(posedge tb_clk);
         #1;
         if (bus.change_key_done) pulses++;
      end
      check("midrst_no_pulse", 128'(pulses), 128'd0);
      read_round(4'd10, "midrst_sched_cleared", '0);
      run_load(hello, 11, lat, pulses);
      check("reload_latency", 128'(lat), 128'(exp_lat));
      check("reload_pulses", 128'(pulses), 128'd1);
      read_round(4'd5, "reload_rk5", hello_rk[5]);
      read_round(4'd9, "reload_rk9", hello_rk[9]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gen_round_keys.md
Name: gen_round_keys

Overview:
AES-128 key-expansion block for the AES accelerator. It captures a 128-bit cipher key, computes and stores all 11 round keys (round 0 = original key, rounds 1-10 per FIPS-197), then serves the key for a requested round with one-cycle latency. It sits between the key-receive interface and the round datapath, which drives cur_round.

Parameters:
None. Fixed AES-128: Nk=4, Nr=10.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
chg_key  in  1  request to load rx_key and regenerate the schedule
rx_key  in  128  new cipher key; bit 127 is the MSB of word w0
cur_round  in  4  round index whose key is requested (0-10 valid)
cur_key  out  128  registered round key for cur_round
orig_key  out  128  registered copy of the last loaded cipher key
change_key_done  out  1  one-cycle pulse when the schedule is complete

Behaviour:
- Reset (n_rst=0, asynchronous): state IDLE; cur_key, orig_key, change_key_done, round counter and all 11 schedule entries = 0.
- State machine: IDLE -> EXPAND -> DONE -> HOLD -> IDLE.
- IDLE: if chg_key=1 at an edge, then orig_key <= rx_key, sched[0] <= rx_key, counter <= 1, go to EXPAND.
- EXPAND: each edge computes sched[counter] from sched[counter-1] and increments counter. After sched[10] is written, go to DONE.
- Key step for round r, with previous words p0..p3 and new words n0..n3:
  - t = SubWord(RotWord(p3)) XOR {Rcon[r], 24'h0}.
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - SubWord uses the standard AES S-box: 4 instances of one combinational function or LUT.
- DONE: change_key_done = 1 for exactly one cycle. Go to HOLD if chg_key=1, otherwise go to IDLE.
- HOLD: wait until chg_key=0, then go to IDLE. A held-high chg_key never retriggers expansion.
- Latency: change_key_done goes high 11 cycles after the edge that samples chg_key.
- chg_key in EXPAND, DONE or HOLD is ignored; rx_key is sampled only on the IDLE start edge.
- cur_key:
  - In every state except EXPAND, each edge loads cur_key <= sched[cur_round] when cur_round <= 10, else 128'h0.
  - During EXPAND cur_key holds its value.
  - Latency is one cycle, so the value is valid 1 cycle after cur_round changes. Any round order is legal, e.g. 10 -> 1.
- orig_key changes only on a load start or reset.
- Reset mid-expansion: aborts, clears everything, no done pulse.

Optional Feature:
- Macro: GRK_FAST_EXPAND_EN.
- Defined: EXPAND computes two rounds per cycle using 8 S-box lookups, so the schedule completes in 5 EXPAND cycles. change_key_done then goes high 6 cycles after the start edge.
- Not defined: one round per cycle as above.
- Round-key values and all other behaviour are identical in both builds.

Test Plan:
- Reset, then hold chg_key=1 with rx_key=68656c6c6f3030303030303030303030 until done -> change_key_done pulses once, 11 cycles after start; orig_key = rx_key.
- After the load, set cur_round=1..10, one per cycle, checking 1 cycle later -> expected keys:
  - 1: 6d616868025158583261686802515858
  - 2: be0b021fbc5a5a478e3b322f8c6a6a77
  - 3: b809f77b0453ad3c8a689f130602f564
  - 4: c7efb414c3bc192849d4863b4fd6735f
  - 5: 21607b90e2dc62b8ab08e483e4de97dc
  - 6: 1ce8fdf9fe349f41553c7bc2b1e2ec1e
  - 7: c4268f313a1210706f2e6bb2decc87ac
  - 8: 0f311e2c35230e5c5a0d65ee84c1e242
  - 9: 6ca93273598a3c2f038759c18746bb83
  - 10: 0043de6459c9e24b5a4ebb8add080009
- cur_round=0 -> cur_key = rx_key. cur_round 10 -> 1 -> key_1 reappears. cur_round=12 -> cur_key=0.
- Hold chg_key=1 for 30 cycles -> exactly one done pulse; release, then assert again with the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Assert n_rst=0 during EXPAND -> all outputs 0 immediately; no done pulse; a later load behaves normally.
- Build with GRK_FAST_EXPAND_EN -> done 6 cycles after start; same round keys.
